// File: rtl/branch_resolver.sv
// MEM-stage branch resolution: in-order prediction queue, mispredict/redirect/flush, predictor training.
// Optional BRANCH_STATS_EN builds saturating branch and mispredict counters.
module branch_resolver #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        branch_decode_sig,
    input  logic        prediction,
    input  logic [31:0] branch_addr,
    input  logic [31:0] pc_decode,
    input  logic        stall,
    input  logic        branch_mem_sig,
    input  logic        actual_branch_decision,
    input  logic [31:0] actual_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        update_valid,
    output logic        update_taken,
    output logic        q_full,
    output logic        q_empty,
    output logic        overflow_err,
    output logic        underflow_err,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e        state_q, state_d;
    logic [31:0]   flush_cnt_q, flush_cnt_d;

    logic          pred_mem [DEPTH];
    logic [31:0]   tgt_mem  [DEPTH];
    logic [31:0]   fall_mem [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic          mispredict_q, update_valid_q, update_taken_q;
    logic [31:0]   redirect_q, redirect_d;
    logic          q_full_q, q_empty_q;
    logic          overflow_q, underflow_q;

    logic          idle, push_req, pop_req, empty_now, full_now, push_ok, pop_ok, mis;
    logic          head_pred;
    logic [31:0]   head_tgt, head_fall;

    always_comb begin
        idle      = (state_q == StIdle);
        push_req  = branch_decode_sig & ~stall & idle;
        pop_req   = branch_mem_sig & idle;
        empty_now = (count_q == '0);
        full_now  = (count_q == CW'(DEPTH));
        pop_ok    = pop_req & ~empty_now;
        // A full queue still accepts a push when the same edge frees a slot.
        push_ok   = push_req & (~full_now | pop_ok);
        head_pred = pred_mem[rd_ptr_q];
        head_tgt  = tgt_mem[rd_ptr_q];
        head_fall = fall_mem[rd_ptr_q];
        mis       = pop_ok & ((actual_branch_decision != head_pred) |
                              (actual_branch_decision & head_pred & (actual_target != head_tgt)));
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        redirect_d = redirect_q;
        if (mis) begin
            // Everything younger than a mispredicted branch is wrong-path, including a same-cycle push.
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            redirect_d = actual_branch_decision ? actual_target : head_fall;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (mis) begin
                    state_d     = StFlush;
                    flush_cnt_d = 32'(FLUSH_CYCLES);
                end
            end
            StFlush: begin
                if (flush_cnt_q <= 32'd1) begin
                    state_d     = StIdle;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            pred_mem[wr_ptr_q] <= prediction;
            tgt_mem[wr_ptr_q]  <= branch_addr;
            fall_mem[wr_ptr_q] <= pc_decode + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            flush_cnt_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            mispredict_q   <= 1'b0;
            update_valid_q <= 1'b0;
            update_taken_q <= 1'b0;
            redirect_q     <= '0;
            q_full_q       <= 1'b0;
            q_empty_q      <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            mispredict_q   <= mis;
            update_valid_q <= pop_ok;
            update_taken_q <= pop_ok & actual_branch_decision;
            redirect_q     <= redirect_d;
            q_full_q       <= (count_d == CW'(DEPTH));
            q_empty_q      <= (count_d == '0);
            overflow_q     <= overflow_q | (push_req & full_now & ~pop_ok);
            underflow_q    <= underflow_q | (pop_req & empty_now);
        end
    end

    assign mispredict    = mispredict_q;
    assign redirect_pc   = redirect_q;
    assign flush         = (state_q == StFlush);
    assign update_valid  = update_valid_q;
    assign update_taken  = update_taken_q;
    assign q_full        = q_full_q;
    assign q_empty       = q_empty_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, mis_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt_q <= '0;
            mis_cnt_q    <= '0;
        end else begin
            if (pop_ok && branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 32'd1;
            if (mis && mis_cnt_q != '1)       mis_cnt_q    <= mis_cnt_q + 32'd1;
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mis_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule
